cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Registered round-robin arbiter and driver for the common data bus (CDB).
- Shares the single broadcast path (BCEN/BCdata/BClabel) among the functional-unit result producers: index 0 alu, 1 mul, 2 div, 3 load/store.
- Replaces the combinational priority helper and bus mux with fair, starvation-bounded selection and a registered broadcast.
- Sits between the functional-unit state machines and the register file and reservation stations, which snoop the bus.

Parameters:
N_REQ, 4, number of requesters; must be a power of two, at least 2
DATA_W, 32, result data width
LABEL_W, 4, reservation-station tag width; tag 0 means "no producer"
WAIT_W, 4, width of each per-requester wait counter
MAX_WAIT, 8, wait count at which a requester becomes starved; must be 1..2^WAIT_W-1

Ports:
clk  in  1  clock; all state changes on rising edge
RST  in  1  asynchronous active-high reset
require  in  N_REQ  per-requester broadcast request; held until accepted
data_in  in  N_REQ*DATA_W  packed results; requester i occupies bits [i*DATA_W +: DATA_W]
label_in  in  N_REQ*LABEL_W  packed result tags, same packing as data_in
cdb_stall  in  1  1 = grant nothing this cycle
accepts  out  N_REQ  one-hot combinational grant in the same cycle as require
BCEN  out  1  registered broadcast valid
BCdata  out  DATA_W  registered broadcast data
BClabel  out  LABEL_W  registered broadcast tag
grant_idx  out  log2(N_REQ)  registered index of the last broadcast source
zero_label_err  out  1  sticky; set when a request carrying tag 0 is granted

Behaviour:
- Reset (RST=1, asynchronous): BCEN=0, BCdata=0, BClabel=0, grant_idx=0, zero_label_err=0, rr_ptr=0, all wait counters=0.
- Outputs are held at reset values while RST is high. The first grant can occur in the first cycle after RST falls.
- Grant rule, per cycle:
  - accepts is all-zero when cdb_stall=1 or require=0.
  - Otherwise exactly one bit is set, chosen as follows.
  - (a) Starved set = requesters with require=1 and wait_cnt==MAX_WAIT. If non-empty, grant its lowest index.
  - (b) Otherwise, grant the first requester with require=1 scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
- Latency:
  - Grant in cycle N latches data_in/label_in of the winner at the end-of-N edge.
  - BCEN=1 with that data and tag for exactly cycle N+1.
  - BCEN=0 in any cycle following a cycle with no grant.
  - BCdata and BClabel hold their last values when BCEN=0.
- Handshake:
  - A requester holds require, data and tag stable until it sees accepts[i]=1.
  - It may deassert require at the edge ending that cycle, or keep it high to present its next result.
  - Dropping require without an accept is legal (withdrawal); no broadcast results.
- rr_ptr:
  - On any grant, rr_ptr <= (granted index + 1) mod N_REQ, including starvation grants.
  - rr_ptr is unchanged when there is no grant.
- Wait counters, per requester i, each edge:
  - Cleared if accepts[i]=1 or require[i]=0.
  - Held if cdb_stall=1.
  - Otherwise incremented, saturating at MAX_WAIT.
- Back-to-back broadcasts: one per cycle is allowed. A requester granted in N may be granted again in N+1 only if it is the sole requester, or is the first requester at or after rr_ptr.
- zero_label_err:
  - Set at the edge ending any grant cycle whose winner's tag is 0.
  - That broadcast is still issued with BCEN=1. Receivers ignore tag 0.
  - Cleared only by RST.
- Simultaneous stall and starvation: stall wins; no grant; counters hold.
- RST asserted mid-broadcast: BCEN drops immediately (asynchronous); the pending result is lost. Requesters re-request after reset.

Test Plan:
- Reset then single request:
  - Stimulus: RST pulse; require=0001, data_in[0]=0x0000_0005, label_in[0]=4'h1.
  - Response: accepts=0001 the same cycle; next cycle BCEN=1, BCdata=5, BClabel=1, grant_idx=0; rr_ptr=1.
- Round-robin fairness:
  - Stimulus: require=1111 held for 8 cycles, with each requester re-requesting after accept.
  - Response: grant order 0,1,2,3,0,1,2,3; BCEN high for 8 consecutive cycles.
- Starvation override:
  - Stimulus: MAX_WAIT=2; requester 3 holds require while requesters 0 and 1 alternate.
  - Response: requester 3 is granted once its wait_cnt reaches 2, ahead of the round-robin choice.
- Stall:
  - Stimulus: require=0110 with cdb_stall=1 for 3 cycles, then stall released.
  - Response: accepts=0 and BCEN=0 throughout the stall; wait counters frozen; first grant after release is index 1 (rr_ptr=0).
- Zero tag and withdrawal:
  - Stimulus: require=0100 with label_in[2]=0; separately, requester 1 raises then drops require without being accepted.
  - Response: broadcast issued with BClabel=0; zero_label_err=1 and sticky; no broadcast for requester 1.
- Asynchronous reset mid-operation:
  - Stimulus: RST asserted mid-cycle while BCEN=1.
  - Response: BCEN, BCdata, BClabel, zero_label_err cleared before the next clock edge; rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_if : result-producer <-> common-data-bus arbiter signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
);
  localparam int c_IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         require;
  logic [N_REQ*DATA_W-1:0]  data_in;
  logic [N_REQ*LABEL_W-1:0] label_in;
  logic                     cdb_stall;
  logic [N_REQ-1:0]         accepts;
  logic                     BCEN;
  logic [DATA_W-1:0]        BCdata;
  logic [LABEL_W-1:0]       BClabel;
  logic [c_IDX_W-1:0]       grant_idx;
  logic                     zero_label_err;

  modport master (
    output require, data_in, label_in, cdb_stall,
    input  accepts, BCEN, BCdata, BClabel, grant_idx, zero_label_err
  );

  modport slave (
    input  require, data_in, label_in, cdb_stall,
    output accepts, BCEN, BCdata, BClabel, grant_idx, zero_label_err
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter : round-robin CDB arbiter with starvation override, registered bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 32,
  parameter int LABEL_W  = 4,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input wire           clk,
  input wire           RST,
  cdb_arbiter_if.slave cdb
);

  localparam int                c_IDX_W    = $clog2(N_REQ);
  localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic                 bcen_q;
  logic [DATA_W-1:0]    bcdata_q;
  logic [LABEL_W-1:0]   bclabel_q;
  logic [c_IDX_W-1:0]   grant_idx_q;
  logic                 zerr_q;
  logic [c_IDX_W-1:0]   rr_ptr_q;
  logic [c_IDX_W-1:0]   rr_ptr_d;
  logic [WAIT_W-1:0]    wait_q [N_REQ];
  logic [WAIT_W-1:0]    wait_d [N_REQ];

  logic                 w_starved_any;
  logic [c_IDX_W-1:0]   w_starved_idx;
  logic [c_IDX_W-1:0]   w_rr_idx;
  logic [c_IDX_W-1:0]   w_scan;
  logic [c_IDX_W-1:0]   w_win;
  logic                 w_grant;
  logic [N_REQ-1:0]     w_accepts;
  logic [DATA_W-1:0]    w_win_data;
  logic [LABEL_W-1:0]   w_win_label;

  always_comb begin
    // Scans run high-to-low so the last hit is the lowest / nearest candidate.
    w_starved_any = 1'b0;
    w_starved_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cdb.require[i] && (wait_q[i] == c_MAX_WAIT)) begin
        w_starved_any = 1'b1;
        w_starved_idx = c_IDX_W'(i);
      end
    end

    w_rr_idx = rr_ptr_q;
    w_scan   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = rr_ptr_q + c_IDX_W'(k);
      if (cdb.require[w_scan]) begin
        w_rr_idx = w_scan;
      end
    end

    w_win   = w_starved_any ? w_starved_idx : w_rr_idx;
    w_grant = !cdb.cdb_stall && (|cdb.require);

    w_accepts   = '0;
    w_win_data  = '0;
    w_win_label = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (c_IDX_W'(i) == w_win) begin
        w_accepts[i] = w_grant;
        w_win_data   = cdb.data_in[i*DATA_W +: DATA_W];
        w_win_label  = cdb.label_in[i*LABEL_W +: LABEL_W];
      end
    end

    // Pointer width is log2(N_REQ), so the +1 wraps modulo N_REQ for free.
    rr_ptr_d = w_grant ? (w_win + c_IDX_W'(1)) : rr_ptr_q;

    for (int i = 0; i < N_REQ; i++) begin
      if (w_accepts[i] || !cdb.require[i]) begin
        wait_d[i] = '0;
      end else if (cdb.cdb_stall || (wait_q[i] == c_MAX_WAIT)) begin
        wait_d[i] = wait_q[i];
      end else begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bcen_q      <= 1'b0;
      bcdata_q    <= '0;
      bclabel_q   <= '0;
      grant_idx_q <= '0;
      zerr_q      <= 1'b0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      bcen_q   <= w_grant;
      rr_ptr_q <= rr_ptr_d;
      if (w_grant) begin
        bcdata_q    <= w_win_data;
        bclabel_q   <= w_win_label;
        grant_idx_q <= w_win;
        if (w_win_label == '0) begin
          zerr_q <= 1'b1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign cdb.accepts        = w_accepts;
  assign cdb.BCEN           = bcen_q;
  assign cdb.BCdata         = bcdata_q;
  assign cdb.BClabel        = bclabel_q;
  assign cdb.grant_idx      = grant_idx_q;
  assign cdb.zero_label_err = zerr_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Main instance uses the default starvation threshold; the second uses 2 so
  // the starvation override can actually beat the round-robin choice.
  cdb_arbiter_if #(.N_REQ(4), .DATA_W(32), .LABEL_W(4)) bus_m ();
  cdb_arbiter_if #(.N_REQ(4), .DATA_W(32), .LABEL_W(4)) bus_s ();

  cdb_arbiter #(
    .N_REQ(4), .DATA_W(32), .LABEL_W(4), .WAIT_W(4), .MAX_WAIT(8)
  ) dut_m (
    .clk(clk),
    .RST(RST),
    .cdb(bus_m)
  );

  cdb_arbiter #(
    .N_REQ(4), .DATA_W(32), .LABEL_W(4), .WAIT_W(4), .MAX_WAIT(2)
  ) dut_s (
    .clk(clk),
    .RST(RST),
    .cdb(bus_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    bus_m.require   = '0;
    bus_m.cdb_stall = 1'b0;
    bus_s.require   = '0;
    bus_s.cdb_stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    zero_inputs();
    @(negedge clk);
    RST = 1'b0;
  endtask

  // Drive one cycle at the falling edge, check the combinational grant, then
  // step past the rising edge so registered outputs can be sampled.
  task automatic cyc_m(input logic [3:0] req, input logic stall, input logic [3:0] exp_acc, input string tag);
    @(negedge clk);
    bus_m.require   = req;
    bus_m.cdb_stall = stall;
    #1;
    check({tag, "/acc"}, bus_m.accepts, exp_acc);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_s(input logic [3:0] req, input logic stall, input logic [3:0] exp_acc, input string tag);
    @(negedge clk);
    bus_s.require   = req;
    bus_s.cdb_stall = stall;
    #1;
    check({tag, "/acc"}, bus_s.accepts, exp_acc);
    @(posedge clk);
    #1;
  endtask

  task automatic bc_m(input string tag, input logic [1:0] idx, input logic [31:0] d, input logic [3:0] l);
    check({tag, "/bcen"},  bus_m.BCEN,      1'b1);
    check({tag, "/idx"},   bus_m.grant_idx, idx);
    check({tag, "/data"},  bus_m.BCdata,    d);
    check({tag, "/label"}, bus_m.BClabel,   l);
  endtask

  task automatic bc_s(input string tag, input logic [1:0] idx, input logic [31:0] d, input logic [3:0] l);
    check({tag, "/bcen"},  bus_s.BCEN,      1'b1);
    check({tag, "/idx"},   bus_s.grant_idx, idx);
    check({tag, "/data"},  bus_s.BCdata,    d);
    check({tag, "/label"}, bus_s.BClabel,   l);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_acc;
    logic [1:0] exp_idx;

    zero_inputs();
    bus_m.data_in  = '0;
    bus_m.label_in = '0;
    bus_s.data_in  = '0;
    bus_s.label_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst/bcen",  bus_m.BCEN,           1'b0);
    check("rst/data",  bus_m.BCdata,         32'h0);
    check("rst/label", bus_m.BClabel,        4'h0);
    check("rst/idx",   bus_m.grant_idx,      2'd0);
    check("rst/zerr",  bus_m.zero_label_err, 1'b0);
    check("rst/acc",   bus_m.accepts,        4'b0000);
    @(negedge clk);
    RST = 1'b0;

    // Single request after reset
    bus_m.data_in[0*32 +: 32] = 32'h0000_0005;
    bus_m.label_in[0*4 +: 4]  = 4'h1;
    cyc_m(4'b0001, 1'b0, 4'b0001, "single");
    bc_m("single", 2'd0, 32'h5, 4'h1);
    cyc_m(4'b0000, 1'b0, 4'b0000, "idle");
    check("idle/bcen",  bus_m.BCEN,    1'b0);
    check("idle/data",  bus_m.BCdata,  32'h5);
    check("idle/label", bus_m.BClabel, 4'h1);

    // rr_ptr=1 after the single grant: 0 and 1 both request, 1 must win
    bus_m.data_in[1*32 +: 32] = 32'h0000_0011;
    bus_m.label_in[1*4 +: 4]  = 4'h2;
    cyc_m(4'b0011, 1'b0, 4'b0010, "rr_ptr1");
    bc_m("rr_ptr1", 2'd1, 32'h11, 4'h2);

    // Round-robin fairness from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus_m.data_in[i*32 +: 32] = 32'h100 + 32'(i);
      bus_m.label_in[i*4 +: 4]  = 4'(i + 1);
    end
    for (int k = 0; k < 8; k++) begin
      exp_idx = 2'(k % 4);
      exp_acc = 4'b0001 << exp_idx;
      cyc_m(4'b1111, 1'b0, exp_acc, "rr");
      bc_m("rr", exp_idx, 32'h100 + 32'(exp_idx), 4'(exp_idx + 2'd1));
    end

    // Stall: nothing granted, then index 1 first from rr_ptr=0
    for (int k = 0; k < 3; k++) begin
      cyc_m(4'b0110, 1'b1, 4'b0000, "stall");
      check("stall/bcen", bus_m.BCEN, 1'b0);
    end
    cyc_m(4'b0110, 1'b0, 4'b0010, "stall_rel");
    bc_m("stall_rel", 2'd1, 32'h101, 4'h2);
    check("no_zerr", bus_m.zero_label_err, 1'b0);

    // Zero tag: broadcast still issued, error sticky
    bus_m.data_in[2*32 +: 32] = 32'hDEAD_BEEF;
    bus_m.label_in[2*4 +: 4]  = 4'h0;
    cyc_m(4'b0100, 1'b0, 4'b0100, "ztag");
    bc_m("ztag", 2'd2, 32'hDEAD_BEEF, 4'h0);
    check("ztag/zerr", bus_m.zero_label_err, 1'b1);

    // Withdrawal of requester 1 without accept
    cyc_m(4'b0010, 1'b1, 4'b0000, "wd_raise");
    check("wd_raise/bcen", bus_m.BCEN, 1'b0);
    cyc_m(4'b0000, 1'b0, 4'b0000, "wd_drop");
    check("wd_drop/bcen",  bus_m.BCEN,           1'b0);
    check("wd_drop/zerr",  bus_m.zero_label_err, 1'b1);
    check("wd_drop/data",  bus_m.BCdata,         32'hDEAD_BEEF);
    check("wd_drop/label", bus_m.BClabel,        4'h0);

    // Asynchronous reset mid-broadcast (rr_ptr=2 before the reset)
    bus_m.data_in[1*32 +: 32] = 32'hCAFE_0001;
    bus_m.label_in[1*4 +: 4]  = 4'h3;
    cyc_m(4'b0010, 1'b0, 4'b0010, "pre_rst");
    bc_m("pre_rst", 2'd1, 32'hCAFE_0001, 4'h3);
    #2;
    RST = 1'b1;
    #1;
    check("arst/bcen",  bus_m.BCEN,           1'b0);
    check("arst/data",  bus_m.BCdata,         32'h0);
    check("arst/label", bus_m.BClabel,        4'h0);
    check("arst/zerr",  bus_m.zero_label_err, 1'b0);
    check("arst/idx",   bus_m.grant_idx,      2'd0);
    @(negedge clk);
    zero_inputs();
    RST = 1'b0;
    bus_m.data_in[0*32 +: 32] = 32'h0000_00A0;
    bus_m.label_in[0*4 +: 4]  = 4'h5;
    bus_m.data_in[3*32 +: 32] = 32'h0000_00A3;
    bus_m.label_in[3*4 +: 4]  = 4'h6;
    cyc_m(4'b1001, 1'b0, 4'b0001, "post_rst");
    bc_m("post_rst", 2'd0, 32'hA0, 4'h5);
    cyc_m(4'b0000, 1'b0, 4'b0000, "post_idle");

    // Starvation override (MAX_WAIT=2): requester 3 beats round-robin choice 2
    for (int i = 0; i < 4; i++) begin
      bus_s.data_in[i*32 +: 32] = 32'h5000 + 32'(i);
      bus_s.label_in[i*4 +: 4]  = 4'(i + 8);
    end
    cyc_s(4'b1001, 1'b0, 4'b0001, "stv1");
    bc_s("stv1", 2'd0, 32'h5000, 4'h8);
    cyc_s(4'b1010, 1'b0, 4'b0010, "stv2");
    bc_s("stv2", 2'd1, 32'h5001, 4'h9);
    cyc_s(4'b1101, 1'b1, 4'b0000, "stv_stall");
    check("stv_stall/bcen", bus_s.BCEN, 1'b0);
    cyc_s(4'b1101, 1'b0, 4'b1000, "stv3");
    bc_s("stv3", 2'd3, 32'h5003, 4'hB);
    cyc_s(4'b0101, 1'b0, 4'b0001, "stv4");
    bc_s("stv4", 2'd0, 32'h5000, 4'h8);
    cyc_s(4'b0100, 1'b0, 4'b0100, "stv5");
    bc_s("stv5", 2'd2, 32'h5002, 4'hA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
